// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris piece randomiser, plus helpers used by
// the bag's invariant checks.
package tetris_pkg;
   typedef logic [2:0] piece_t;

   localparam int     NUM_PIECES = 7;
   localparam piece_t PIECE_NONE = 3'd7;
   localparam int     BAG_W      = 21;

   function automatic logic [2:0] popcount7(input logic [6:0] flags);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < NUM_PIECES; i++) begin
         n = n + {2'b00, flags[i]};
      end
      return n;
   endfunction

   // Only slots below cnt are occupied; empty slots read 0 and must not count.
   function automatic logic bag_has_dup(input logic [BAG_W-1:0] bag, input logic [2:0] cnt);
      for (int i = 0; i < NUM_PIECES; i++) begin
         for (int j = i + 1; j < NUM_PIECES; j++) begin
            if ((3'(j) < cnt) && (bag[3*i +: 3] == bag[3*j +: 3])) begin
               return 1'b1;
            end
         end
      end
      return 1'b0;
   endfunction
endpackage

// File: rtl/piece_bag_if.sv
// Candidate-piece input and collected-bag output of the 7-bag accumulator.
interface piece_bag_if;
   import tetris_pkg::*;

   logic             newbag;
   logic             newpiece;
   piece_t           piece;
   logic             done;
   logic [BAG_W-1:0] bag;

   modport master (output newbag, output newpiece, output piece, input done, input bag);
   modport slave  (input newbag, input newpiece, input piece, output done, output bag);
endinterface

// File: rtl/piece_bag.sv
// 7-bag accumulator: records each piece ID 0..6 once, in arrival order, and flags
// when all seven are present. Accepts one candidate per cycle; rejects silently.
module piece_bag
   import tetris_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   piece_bag_if.slave bus
);

   logic [BAG_W-1:0] bag_q, bag_d;
   logic [6:0]       bagflags, bagflags_d;
   logic [2:0]       count_q, count_d;
   logic             done_q, done_d;
   logic [7:0]       flags_ext;
   logic             accept;

   // Bit 7 is tied high so the invalid ID reads as "already taken".
   assign flags_ext = {1'b1, bagflags};
   assign accept    = bus.newpiece
                   && (bus.piece != PIECE_NONE)
                   && !flags_ext[bus.piece]
                   && (count_q != 3'(NUM_PIECES));

   always_comb begin
      bag_d      = bag_q;
      bagflags_d = bagflags;
      count_d    = count_q;
      if (bus.newbag) begin
         bag_d      = '0;
         bagflags_d = '0;
         count_d    = '0;
      end else if (accept) begin
         for (int k = 0; k < NUM_PIECES; k++) begin
            if (count_q == 3'(k)) begin
               bag_d[3*k +: 3] = bus.piece;
            end
         end
         bagflags_d = bagflags | 7'(8'd1 << bus.piece);
         count_d    = count_q + 3'd1;
      end
      done_d = (bagflags_d == 7'h7F);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bag_q    <= '0;
         bagflags <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         bag_q    <= bag_d;
         bagflags <= bagflags_d;
         count_q  <= count_d;
         done_q   <= done_d;
      end
   end

   assign bus.done = done_q;
   assign bus.bag  = bag_q;

   a_count_pop : assert property (@(posedge clk) disable iff (reset)
      count_q == popcount7(bagflags));
   a_done_full : assert property (@(posedge clk) disable iff (reset)
      done_q == (&bagflags));
   a_no_dup    : assert property (@(posedge clk) disable iff (reset)
      !bag_has_dup(bag_q, count_q));

endmodule

// File: tb/tb_piece_bag.sv
// Randomised and directed bench for piece_bag against a queue-based model of the bag.
module tb_piece_bag;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   mq[$];

   piece_bag_if bif();

   piece_bag dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit in_bag(input int id);
      foreach (mq[i]) if (mq[i] == id) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] exp_bag();
      logic [31:0] b = '0;
      foreach (mq[i]) b[3*i +: 3] = 3'(mq[i]);
      return b;
   endfunction

   function automatic logic [31:0] exp_flags();
      logic [31:0] f = '0;
      foreach (mq[i]) f[mq[i]] = 1'b1;
      return f;
   endfunction

   function automatic void model_step(input logic nb, input logic np, input int p);
      if (nb) mq.delete();
      else if (np && p < 7 && !in_bag(p) && mq.size() < 7) mq.push_back(p);
   endfunction

   task automatic compare_all(input string tag);
      check_val({tag, "_bag"},   32'(bif.bag),      exp_bag());
      check_val({tag, "_flags"}, 32'(dut.bagflags), exp_flags());
      check_val({tag, "_count"}, 32'(dut.count_q),  32'(mq.size()));
      check_val({tag, "_done"},  32'(bif.done),     32'(mq.size() == 7));
   endtask

   // Called at a negedge: drive, let one posedge pass, compare at the next negedge.
   task automatic cyc(input string tag, input logic nb, input logic np, input int p);
      bif.newbag   = nb;
      bif.newpiece = np;
      bif.piece    = 3'(p);
      @(posedge clk);
      model_step(nb, np, p);
      @(negedge clk);
      compare_all(tag);
   endtask

   initial begin
      int perm[7];
      int idx, guard, r, t;
      logic [31:0] perm_bag;

      reset = 1'b1;
      bif.newbag = 1'b0; bif.newpiece = 1'b0; bif.piece = 3'd0;
      repeat (2) @(negedge clk);
      compare_all("reset");
      reset = 1'b0;

      // Async reset mid-sequence
      cyc("pre_rst", 0, 1, 2);
      cyc("pre_rst", 0, 1, 5);
      cyc("pre_rst", 0, 1, 0);
      reset = 1'b1;
      #2;
      check_val("async_rst_bag",   32'(bif.bag),      32'd0);
      check_val("async_rst_flags", 32'(dut.bagflags), 32'd0);
      check_val("async_rst_done",  32'(bif.done),     32'd0);
      mq.delete();
      @(negedge clk);
      reset = 1'b0;

      // Descending sequence including the invalid ID
      for (int p = 7; p >= 0; p--) cyc("seq", 0, 1, p);
      check_val("seq_bag_final", 32'(bif.bag),
                32'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}));
      check_val("seq_flags_final", 32'(dut.bagflags), 32'h7F);
      check_val("seq_done_final",  32'(bif.done),     32'd1);

      // Full bag is frozen
      cyc("full", 0, 1, 2);
      check_val("full_bag_frozen", 32'(bif.bag),
                32'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}));

      // newbag clears; newbag wins over a simultaneous newpiece
      cyc("newbag", 1, 0, 0);
      check_val("newbag_done", 32'(bif.done), 32'd0);
      cyc("nb_np", 1, 1, 4);
      check_val("nb_np_bag", 32'(bif.bag), 32'd0);

      // Duplicate rejection
      cyc("dup", 0, 1, 3);
      cyc("dup", 0, 1, 3);
      check_val("dup_flags", 32'(dut.bagflags), 32'b0001000);
      check_val("dup_count", 32'(dut.count_q),  32'd1);
      check_val("dup_bag",   32'(bif.bag),      32'd3);

      // Random permutations with interleaved duplicates, invalid IDs and idles
      for (int round = 0; round < 25; round++) begin
         cyc("rnd_clr", 1, 0, 0);
         for (int i = 0; i < 7; i++) perm[i] = i;
         for (int i = 6; i > 0; i--) begin
            int j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
         end
         idx = 0;
         guard = 0;
         while (idx < 7 && guard < 200) begin
            guard++;
            r = $urandom_range(0, 3);
            if (r == 0) begin
               cyc("rnd", 0, 1, perm[idx]);
               idx++;
            end else if (r == 1) begin
               cyc("rnd_inv", 0, 1, 7);
            end else if (r == 2 && mq.size() > 0) begin
               cyc("rnd_dup", 0, 1, mq[$urandom_range(0, mq.size() - 1)]);
            end else begin
               cyc("rnd_idle", 0, 0, int'($urandom_range(0, 7)));
            end
         end
         if (idx < 7) check_val("rnd_budget", 32'(idx), 32'd7);
         perm_bag = '0;
         for (int i = 0; i < 7; i++) perm_bag[3*i +: 3] = 3'(perm[i]);
         check_val("perm_bag",  32'(bif.bag),  perm_bag);
         check_val("perm_done", 32'(bif.done), 32'd1);
         cyc("rnd_full", 0, 1, int'($urandom_range(0, 7)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
